// File: rtl/rst_seq_xil7series.sv
// rst_seq_xil7series: qualifies MMCM lock, then releases peripheral reset and, StretchCycles later, system reset
// Ports: clk_i, rst_ni (async active-low), pll_locked_i (async), sw_rst_req_i,
//        rst_periph_no, rst_sys_no, rst_cause_o, lock_lost_o, lock_timeout_o.
// Optional: define RST_SEQ_LOCK_TIMEOUT_EN to build the WAIT_LOCK timeout flag.
module rst_seq_xil7series #(
    parameter int unsigned SyncStages        = 2,
    parameter int unsigned LockFilterCycles  = 16,
    parameter int unsigned StretchCycles     = 64,
    parameter int unsigned LockTimeoutCycles = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_sys_no,
    output logic [1:0] rst_cause_o,
    output logic       lock_lost_o,
    output logic       lock_timeout_o
);
    localparam int unsigned MaxAB     = (LockFilterCycles > StretchCycles) ? LockFilterCycles : StretchCycles;
    localparam int unsigned MaxCycles = (MaxAB > LockTimeoutCycles) ? MaxAB : LockTimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] FiltLast    = CntW'(LockFilterCycles - 1);
    localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);

    typedef enum logic [1:0] {WAIT_LOCK, PERIPH_REL, RUN} state_t;

    state_t              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [SyncStages-1:0] sync_q;
    logic                lock_s;
    logic                periph_q;
    logic                sys_q;
    logic [1:0]          cause_q;
    logic                lost_q;

    assign lock_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SyncStages-2:0], pll_locked_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            sys_q    <= 1'b0;
            cause_q  <= 2'b00;
            lost_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) cnt_q <= '0;
                    else if (cnt_q == FiltLast) begin
                        state_q  <= PERIPH_REL;
                        cnt_q    <= '0;
                        periph_q <= 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                PERIPH_REL: begin
                    if (!lock_s) begin
                        state_q  <= WAIT_LOCK;
                        cnt_q    <= '0;
                        periph_q <= 1'b0;
                        cause_q  <= 2'b10;
                        lost_q   <= 1'b1;
                    end else if (cnt_q == StretchLast) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        sys_q   <= 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                RUN: begin
                    // lock loss takes priority over a coincident software request
                    if (!lock_s || sw_rst_req_i) begin
                        state_q  <= WAIT_LOCK;
                        cnt_q    <= '0;
                        periph_q <= 1'b0;
                        sys_q    <= 1'b0;
                        cause_q  <= !lock_s ? 2'b10 : 2'b01;
                        lost_q   <= lost_q | !lock_s;
                    end
                end
                default: begin
                    state_q  <= WAIT_LOCK;
                    cnt_q    <= '0;
                    periph_q <= 1'b0;
                    sys_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CntW-1:0] TmoLast = CntW'(LockTimeoutCycles - 1);
    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_q;

    // counts every WAIT_LOCK cycle regardless of lock_s and saturates at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (state_q != WAIT_LOCK) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q == TmoLast) begin
            tmo_q <= 1'b1;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign lock_timeout_o = tmo_q;
`else
    assign lock_timeout_o = 1'b0;
`endif

    assign rst_periph_no = periph_q;
    assign rst_sys_no    = sys_q;
    assign rst_cause_o   = cause_q;
    assign lock_lost_o   = lost_q;
endmodule

// File: tb/tb_rst_seq_xil7series.sv
// tb_rst_seq_xil7series: table and scoreboard bench for the reset sequencer
module tb_rst_seq_xil7series;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll = 1'b0;
    logic       sw = 1'b0;
    logic       periph;
    logic       sys;
    logic [1:0] cause;
    logic       lost;
    logic       tmo;
    int         tests = 0;
    int         fails = 0;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       lock;
        logic       req;
        int         n;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[17];

    rst_seq_xil7series #(
        .SyncStages(2),
        .LockFilterCycles(16),
        .StretchCycles(64),
        .LockTimeoutCycles(100)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .pll_locked_i(pll),
        .sw_rst_req_i(sw),
        .rst_periph_no(periph),
        .rst_sys_no(sys),
        .rst_cause_o(cause),
        .lock_lost_o(lost),
        .lock_timeout_o(tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {periph, sys, cause, lost, tmo};
    endfunction

    task automatic chk(input string name, input logic [5:0] exp);
        tests++;
        if (obs() !== exp) begin
            fails++;
            $display("FAIL %s got {periph,sys,cause,lost,tmo}=%b expected %b", name, obs(), exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lock_val);
        pll = lock_val;
        sw = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("in_reset", 6'b000000);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (sys && !periph) begin
                fails++;
                $display("FAIL sys_implies_periph got sys=%b periph=%b expected periph=1", sys, periph);
            end
        end
    end

    initial begin
        sb_t e;
        vecs[0]  = '{"t_por_hold",    1'b1, 1'b0, 17, 6'b000000};
        vecs[1]  = '{"t_periph",      1'b1, 1'b0, 1,  6'b100000};
        vecs[2]  = '{"t_stretch",     1'b1, 1'b0, 63, 6'b100000};
        vecs[3]  = '{"t_run",         1'b1, 1'b0, 1,  6'b110000};
        vecs[4]  = '{"t_sw",          1'b1, 1'b1, 1,  6'b000100};
        vecs[5]  = '{"t_sw_filter",   1'b1, 1'b0, 15, 6'b000100};
        vecs[6]  = '{"t_sw_periph",   1'b1, 1'b0, 1,  6'b100100};
        vecs[7]  = '{"t_loss_sync",   1'b0, 1'b0, 2,  6'b100100};
        vecs[8]  = '{"t_loss_periph", 1'b0, 1'b0, 1,  6'b001010};
        vecs[9]  = '{"t_wait_low",    1'b0, 1'b0, 30, 6'b001010};
        vecs[10] = '{"t_relock_hold", 1'b1, 1'b0, 17, 6'b001010};
        vecs[11] = '{"t_relock",      1'b1, 1'b0, 1,  6'b101010};
        vecs[12] = '{"t_run2",        1'b1, 1'b0, 64, 6'b111010};
        vecs[13] = '{"t_sw_keeplost", 1'b1, 1'b1, 1,  6'b000110};
        vecs[14] = '{"t_sw_in_wait",  1'b1, 1'b1, 1,  6'b000110};
        vecs[15] = '{"t_after_wait",  1'b1, 1'b0, 14, 6'b000110};
        vecs[16] = '{"t_periph3",     1'b1, 1'b0, 1,  6'b100110};

        // POR release with lock stable
        do_reset(1'b1);
        edges(17); chk("por_edge17", 6'b000000);
        edges(1);  chk("por_periph_edge18", 6'b100000);
        edges(63); chk("por_edge81", 6'b100000);
        edges(1);  chk("por_sys_edge82", 6'b110000);
        // lock loss in RUN, then full re-sequence
        edges(100);
        pll = 1'b0;
        edges(2);  chk("loss_sync_delay", 6'b110000);
        edges(1);  chk("loss_run", 6'b001010);
        pll = 1'b1;
        edges(17); chk("relock_hold", 6'b001010);
        edges(1);  chk("relock_periph", 6'b101010);
        edges(63); chk("relock_stretch", 6'b101010);
        edges(1);  chk("relock_sys", 6'b111010);
        // software reset in RUN, ignored in PERIPH_REL
        sw = 1'b1; edges(1); sw = 1'b0;
        chk("sw_run", 6'b000110);
        edges(15); chk("sw_filter", 6'b000110);
        edges(1);  chk("sw_periph", 6'b100110);
        edges(5);
        sw = 1'b1; edges(1); sw = 1'b0;
        chk("sw_ignored_periph", 6'b100110);
        edges(57); chk("sw_ignored_stretch", 6'b100110);
        edges(1);  chk("sw_ignored_sys", 6'b110110);
        // simultaneous lock loss and software request
        pll = 1'b0;
        edges(2);
        sw = 1'b1; edges(1); sw = 1'b0;
        chk("simultaneous", 6'b001010);
        // async reset in the middle of PERIPH_REL
        pll = 1'b1;
        edges(18); chk("pre_async_periph", 6'b101010);
        edges(10);
        #2 rst_n = 1'b0;
        #1 chk("async_assert", 6'b000000);
        // glitch during the lock filter
        do_reset(1'b1);
        edges(10); pll = 1'b0;
        edges(1);  pll = 1'b1;
        edges(17); chk("glitch_edge28", 6'b000000);
        edges(1);  chk("glitch_periph_edge29", 6'b100000);
        // lock held low: timeout flag only in the macro build
        do_reset(1'b0);
        edges(99); chk("tmo_edge99", 6'b000000);
        edges(1);  chk("tmo_edge100", {5'b00000, TMO_EN});
        edges(50); chk("tmo_sticky", {5'b00000, TMO_EN});
        pll = 1'b1;
        edges(18); chk("tmo_then_periph", {5'b10000, TMO_EN});
        // table-driven phases through the scoreboard
        do_reset(1'b1);
        for (int i = 0; i < 17; i++) begin
            pll = vecs[i].lock;
            sw = vecs[i].req;
            sb.push_back('{vecs[i].name, vecs[i].exp});
            edges(vecs[i].n);
            sw = 1'b0;
            e = sb.pop_front();
            chk(e.name, e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rst_seq_xil7series.md
Name: rst_seq_xil7series

Overview:
- Reset sequencer between the board reset button / MMCM lock and the SoC reset inputs on the Nexys Video build.
- Qualifies the clock generator's lock signal, then releases peripheral reset first and system (core) reset a fixed number of cycles later.
- Re-enters reset on lock loss or a software reset request, and records the cause.
- Output rst_sys_no drives the top-level rst_ni; rst_periph_no feeds peripheral/USB reset domains.

Parameters:
- SyncStages, 2: flops in the pll_locked_i synchronizer (legal values 2..4).
- LockFilterCycles, 16: consecutive synchronized-lock-high cycles required before peripheral release (legal values ≥1).
- StretchCycles, 64: cycles between peripheral release and system release (legal values ≥1).
- LockTimeoutCycles, 4096: WAIT_LOCK cycle limit used only by the optional feature.

Ports:
- clk_i  in  1  system clock (MMCM output, already BUFG'd).
- rst_ni  in  1  asynchronous active-low reset (board IO_RST_N).
- pll_locked_i  in  1  MMCM locked; asynchronous to clk_i.
- sw_rst_req_i  in  1  single-cycle software/debug reset request, synchronous to clk_i.
- rst_periph_no  out  1  peripheral reset, active-low.
- rst_sys_no  out  1  core/system reset, active-low.
- rst_cause_o  out  2  last reset cause: 00 = power-on/button, 01 = software, 10 = lock loss, 11 = reserved.
- lock_lost_o  out  1  sticky flag: a lock loss has occurred since rst_ni.
- lock_timeout_o  out  1  lock timeout flag (optional feature; tied 0 when compiled out).

Behaviour:
- Reset domain: one clock, clk_i. rst_ni is asynchronous and active-low.
- Assertion of rst_ni is asynchronous. Every flop takes its reset value immediately:
  - state = WAIT_LOCK, counter = 0, sync chain = 0.
  - rst_periph_no = 0, rst_sys_no = 0.
  - rst_cause_o = 00, lock_lost_o = 0, lock_timeout_o = 0.
- Deassertion takes effect on the first clk_i edge after rst_ni rises.
- lock_s is pll_locked_i after SyncStages flops; only lock_s is used internally.
- Outputs are registered. They change on the same edge as the state transition that implies them.
- State machine:
  - WAIT_LOCK: both resets low.
    - lock_s = 1: counter increments; lock_s = 0: counter clears.
    - When lock_s = 1 and counter == LockFilterCycles-1: go to PERIPH_REL, counter clears, rst_periph_no goes 1.
  - PERIPH_REL: rst_periph_no = 1, rst_sys_no = 0; counter increments every cycle.
    - At counter == StretchCycles-1: go to RUN, rst_sys_no goes 1.
    - lock_s = 0 at any point: go to WAIT_LOCK, rst_periph_no goes 0, cause = 10, lock_lost_o = 1.
  - RUN: both resets 1.
    - lock_s = 0: go to WAIT_LOCK, both resets go 0, cause = 10, lock_lost_o = 1.
    - Otherwise sw_rst_req_i = 1: go to WAIT_LOCK, both resets go 0, cause = 01.
- sw_rst_req_i is ignored outside RUN.
- Simultaneous lock loss and sw request: lock loss wins (cause 10).
- rst_cause_o holds its value until the next cause event or rst_ni.
- lock_lost_o is cleared only by rst_ni.
- Both resets deassert synchronously to clk_i and never glitch.
- rst_sys_no = 1 implies rst_periph_no = 1 at every cycle.
- Counter width: $clog2(max(LockFilterCycles, StretchCycles, LockTimeoutCycles)) + 1. The counter never wraps, because every state clears it on exit.
- Latency with defaults and lock stable high:
  - rst_periph_no rises 18 edges after the first edge with rst_ni high.
  - rst_sys_no rises 64 edges after rst_periph_no.

Optional Feature:
- Macro: RST_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - Counts cycles spent in WAIT_LOCK regardless of lock_s, using a separate counter that clears on leaving WAIT_LOCK.
  - Reaching LockTimeoutCycles sets sticky lock_timeout_o = 1, cleared only by rst_ni.
  - The sequence continues to wait normally; resets stay asserted.
- Undefined: lock_timeout_o is constant 0 and no timeout counter is built.

Test Plan:
- POR release: rst_ni low 5 cycles then high, pll_locked_i high throughout, defaults -> rst_periph_no rises at edge 18, rst_sys_no at edge 82, rst_cause_o = 00.
- Lock glitch during filter: lock_s drops for 1 cycle after 10 good cycles -> counter restarts; periph release is 16 full lock cycles after the glitch.
- Lock loss in RUN: pll_locked_i low at cycle 200 -> both resets 0 SyncStages+1 edges later, rst_cause_o = 10, lock_lost_o = 1; lock restored -> full 16+64 sequence repeats.
- Software reset: sw_rst_req_i pulse in RUN -> both resets 0 next edge, cause = 01; same pulse during PERIPH_REL -> ignored.
- Simultaneous lock_s fall and sw_rst_req_i in RUN -> cause = 10; async rst_ni assert mid-PERIPH_REL -> outputs 0 with no clock, lock_lost_o cleared.
- With RST_SEQ_LOCK_TIMEOUT_EN and LockTimeoutCycles = 100, lock held low -> lock_timeout_o = 1 at cycle 100 and stays; without the macro -> stays 0.
